// File: rtl/wb_stream_writer_if.sv
// Bus bundle for wb_stream_writer: Wishbone read master, stream master and Wishbone config slave.
// master = engine side, slave = memory / sink / configuring host side.
interface wb_stream_writer_if #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
);
    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW-1:0]   wbm_dat_o;
    logic [WB_DW/8-1:0] wbm_sel_o;
    logic               wbm_we_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic [2:0]         wbm_cti_o;
    logic [1:0]         wbm_bte_o;
    logic [WB_DW-1:0]   wbm_dat_i;
    logic               wbm_ack_i;
    logic               wbm_err_i;
    logic               wbm_rty_i;

    logic [WB_DW-1:0]   stream_m_data_o;
    logic               stream_m_valid_o;
    logic               stream_m_ready_i;
    logic               irq_o;

    logic [4:0]         wbs_adr_i;
    logic [WB_DW-1:0]   wbs_dat_i;
    logic [WB_DW/8-1:0] wbs_sel_i;
    logic               wbs_we_i;
    logic               wbs_cyc_i;
    logic               wbs_stb_i;
    logic [2:0]         wbs_cti_i;
    logic [1:0]         wbs_bte_i;
    logic [WB_DW-1:0]   wbs_dat_o;
    logic               wbs_ack_o;
    logic               wbs_err_o;
    logic               wbs_rty_o;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
               wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        output stream_m_data_o, stream_m_valid_o,
        input  stream_m_ready_i,
        output irq_o,
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
               wbs_cti_i, wbs_bte_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
               wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
        input  stream_m_data_o, stream_m_valid_o,
        output stream_m_ready_i,
        input  irq_o,
        output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
               wbs_cti_i, wbs_bte_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/wb_stream_writer.sv
// Memory-to-stream DMA: Wishbone burst reads into a FWFT FIFO drained on a valid/ready stream.
// Optional circular-buffer mode (CSR bit3) enabled by defining WB_STREAM_WRITER_REPEAT_EN.
module wb_stream_writer #(
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 32,
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32
) (
    input logic               clk,
    input logic               rst_n,
    wb_stream_writer_if.master bus_io
);
    localparam int BYTES = WB_DW / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int LIM   = (MAX_BURST_LEN < DEPTH) ? MAX_BURST_LEN : DEPTH;
    localparam logic [WB_DW-1:0]   LIM_W   = WB_DW'(LIM);
    localparam logic [WB_DW-1:0]   DEPTH_W = WB_DW'(DEPTH);
    localparam logic [WB_DW-1:0]   ONE_W   = WB_DW'(1);
    localparam logic [WB_AW-1:0]   STEP    = WB_AW'(BYTES);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [WB_AW-1:0]   ptr_q, ptr_d;
    logic [WB_DW-1:0]   rem_q, rem_d;
    logic [WB_DW-1:0]   beats_q, beats_d;
    logic               irq_q, irq_d;
    logic               err_q, err_d;
    logic               ack_q;
    logic [WB_DW-1:0]   rdat_q, rdata_d;
    logic [WB_AW-1:0]   start_addr_q;
    logic [WB_DW-1:0]   buf_size_q;
    logic [WB_DW-1:0]   burst_size_q;
    logic               repeat_q;

    logic [WB_DW-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;

    logic               cyc, push, pop, flush, fifo_empty, busy;
    logic [2:0]         cti;
    logic               cfg_req, cfg_wr, start_req, clr_req;
    logic [WB_DW-1:0]   buf_words, eb, n_words, free_w;
    logic               unused_ok;

    assign busy       = (state_q != S_IDLE);
    assign buf_words  = buf_size_q >> SHIFT;
    assign eb         = (burst_size_q == '0) ? ONE_W : ((burst_size_q > LIM_W) ? LIM_W : burst_size_q);
    assign n_words    = (eb < rem_q) ? eb : rem_q;
    assign free_w     = DEPTH_W - WB_DW'(count_q);
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && bus_io.stream_m_ready_i;

    assign cfg_req   = bus_io.wbs_cyc_i && bus_io.wbs_stb_i && !ack_q;
    assign cfg_wr    = cfg_req && bus_io.wbs_we_i;
    assign start_req = cfg_wr && (bus_io.wbs_adr_i == 5'h00) && bus_io.wbs_dat_i[0] && !busy;
    assign clr_req   = cfg_wr && (bus_io.wbs_adr_i == 5'h00) && bus_io.wbs_dat_i[1];

    assign bus_io.wbm_adr_o        = cyc ? ptr_q : '0;
    assign bus_io.wbm_dat_o        = '0;
    assign bus_io.wbm_sel_o        = '1;
    assign bus_io.wbm_we_o         = 1'b0;
    assign bus_io.wbm_cyc_o        = cyc;
    assign bus_io.wbm_stb_o        = cyc;
    assign bus_io.wbm_cti_o        = cti;
    assign bus_io.wbm_bte_o        = 2'b00;
    assign bus_io.stream_m_valid_o = !fifo_empty;
    assign bus_io.stream_m_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign bus_io.irq_o            = irq_q;
    assign bus_io.wbs_dat_o        = rdat_q;
    assign bus_io.wbs_ack_o        = ack_q;
    assign bus_io.wbs_err_o        = 1'b0;
    assign bus_io.wbs_rty_o        = 1'b0;

    assign unused_ok = ^{bus_io.wbm_rty_i, bus_io.wbs_sel_i, bus_io.wbs_cti_i, bus_io.wbs_bte_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        irq_d   = irq_q;
        err_d   = err_q;
        cyc     = 1'b0;
        cti     = 3'b000;
        push    = 1'b0;
        flush   = 1'b0;
        // Clear first so that a completion in the same cycle still raises irq.
        if (clr_req) begin
            irq_d = 1'b0;
            err_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if (buf_words == '0) begin
                        irq_d = 1'b1;
                    end else begin
                        ptr_d   = start_addr_q;
                        rem_d   = buf_words;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (free_w >= n_words) begin
                    beats_d = n_words;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                cyc = 1'b1;
                cti = (beats_q == ONE_W) ? 3'b111 : 3'b010;
                if (bus_io.wbm_err_i) begin
                    err_d   = 1'b1;
                    irq_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end else if (bus_io.wbm_ack_i) begin
                    push    = 1'b1;
                    ptr_d   = ptr_q + STEP;
                    rem_d   = rem_q - ONE_W;
                    beats_d = beats_q - ONE_W;
                    if (beats_q == ONE_W) begin
                        state_d = (rem_q == ONE_W) ? S_DRAIN : S_WAIT;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    irq_d = 1'b1;
`ifdef WB_STREAM_WRITER_REPEAT_EN
                    if (repeat_q) begin
                        ptr_d   = start_addr_q;
                        rem_d   = buf_words;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        case (bus_io.wbs_adr_i)
            5'h00: rdata_d[3:0] = {repeat_q, err_q, irq_q, busy};
            5'h04: rdata_d = WB_DW'(start_addr_q);
            5'h08: rdata_d = buf_size_q;
            5'h0C: rdata_d = burst_size_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= 1'b0;
            rdat_q       <= '0;
            start_addr_q <= '0;
            buf_size_q   <= '0;
            burst_size_q <= '0;
            repeat_q     <= 1'b0;
        end else begin
            ack_q  <= cfg_req;
            rdat_q <= cfg_req ? rdata_d : '0;
            if (cfg_wr && !busy) begin
                case (bus_io.wbs_adr_i)
                    5'h04: start_addr_q <= WB_AW'(bus_io.wbs_dat_i);
                    5'h08: buf_size_q   <= bus_io.wbs_dat_i;
                    5'h0C: burst_size_q <= bus_io.wbs_dat_i;
                    default: ;
                endcase
            end
`ifdef WB_STREAM_WRITER_REPEAT_EN
            if (cfg_wr && (bus_io.wbs_adr_i == 5'h00)) begin
                repeat_q <= bus_io.wbs_dat_i[3];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus_io.wbm_dat_i;
    end
endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed bench for wb_stream_writer: zero-wait memory model, stream sink and config host.
module tb_wb_stream_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    wb_stream_writer_if #(.WB_AW(32), .WB_DW(32)) bus ();

    wb_stream_writer #(
        .FIFO_AW(5), .MAX_BURST_LEN(32), .WB_AW(32), .WB_DW(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus_io(bus)
    );

    // Memory model: word at byte address A holds 0xC0DE0000 ^ (A >> 2)
    logic        err_en = 1'b0;
    int          err_at = 0;
    int          ack_limit = 1 << 30;
    int          beat_cnt = 0;
    logic [31:0] beat_adr [$];
    logic [2:0]  beat_cti [$];
    logic [31:0] str_q [$];

    always_comb begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_rty_i = 1'b0;
        bus.wbm_dat_i = '0;
        if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
            bus.wbm_dat_i = 32'hC0DE_0000 ^ (bus.wbm_adr_o >> 2);
            if (err_en && beat_cnt == err_at) bus.wbm_err_i = 1'b1;
            else if (beat_cnt < ack_limit)     bus.wbm_ack_i = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) begin
            beat_adr.push_back(bus.wbm_adr_o);
            beat_cti.push_back(bus.wbm_cti_o);
            beat_cnt <= beat_cnt + 1;
        end
        if (bus.stream_m_valid_o && bus.stream_m_ready_i) str_q.push_back(bus.stream_m_data_o);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        bus.wbs_adr_i = a; bus.wbs_dat_i = d; bus.wbs_we_i = 1'b1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.wbs_ack_o !== 1'b1 && n < 20);
        if (bus.wbs_ack_o !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL wb_write_ack: got no ack expected ack at adr %h", a);
        end
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        bus.wbs_adr_i = a; bus.wbs_we_i = 1'b0;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.wbs_ack_o !== 1'b1 && n < 20);
        d = bus.wbs_dat_o;
        if (bus.wbs_ack_o !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL wb_read_ack: got no ack expected ack at adr %h", a);
        end
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    endtask

    task automatic wait_irq(input int max, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            @(negedge clk);
            if (bus.irq_o === 1'b1) ok = 1'b1;
            n++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        @(posedge clk); #1;
        tests_run++;
        if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.stream_m_valid_o, bus.irq_o, bus.wbs_ack_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000", {bus.wbm_cyc_o, bus.wbm_stb_o,
                     bus.stream_m_valid_o, bus.irq_o, bus.wbs_ack_o});
        end
        tests_run++;
        if (bus.wbm_sel_o !== 4'hF || bus.wbm_adr_o !== 32'h0 || bus.wbm_cti_o !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_bus: got sel %h adr %h cti %b expected f 0 000",
                     bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_cti_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wb_read(5'h00, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_csr: got %h expected 0", d); end
        wb_read(5'h08, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_bufsize: got %h expected 0", d); end
    endtask

    task automatic test_basic;
        int bb = beat_cnt;
        int sb = str_q.size();
        bit ok;
        logic [31:0] d;
        bus.stream_m_ready_i = 1'b1;
        wb_write(5'h04, 32'h40);
        wb_write(5'h08, 32'd32);
        wb_write(5'h0C, 32'd4);
        wb_write(5'h00, 32'h1);
        wait_irq(300, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL basic_irq: got 0 expected 1"); end
        tests_run++;
        if (beat_cnt - bb !== 8) begin tests_failed++; $display("FAIL basic_beats: got %0d expected 8", beat_cnt - bb); end
        for (int i = 0; i < 8; i++) begin
            if (bb + i < beat_adr.size()) begin
                tests_run++;
                if (beat_adr[bb+i] !== 32'h40 + 32'(4 * i) || beat_cti[bb+i] !== ((i % 4 == 3) ? 3'b111 : 3'b010)) begin
                    tests_failed++;
                    $display("FAIL basic_beat%0d: got adr %h cti %b expected adr %h cti %b", i,
                             beat_adr[bb+i], beat_cti[bb+i], 32'h40 + 32'(4 * i), (i % 4 == 3) ? 3'b111 : 3'b010);
                end
            end
        end
        tests_run++;
        if (str_q.size() - sb !== 8) begin tests_failed++; $display("FAIL basic_words: got %0d expected 8", str_q.size() - sb); end
        for (int i = 0; i < 8; i++) begin
            if (sb + i < str_q.size()) begin
                tests_run++;
                if (str_q[sb+i] !== (32'hC0DE_0010 + 32'(i))) begin
                    tests_failed++;
                    $display("FAIL basic_data%0d: got %h expected %h", i, str_q[sb+i], 32'hC0DE_0010 + 32'(i));
                end
            end
        end
        wb_read(5'h00, d);
        tests_run++;
        if (d !== 32'h2) begin tests_failed++; $display("FAIL basic_csr: got %h expected 2", d); end
        wb_write(5'h00, 32'h2);
        tests_run++;
        if (bus.irq_o !== 1'b0) begin tests_failed++; $display("FAIL basic_irqclr: got %b expected 0", bus.irq_o); end
    endtask

    task automatic test_partial_burst;
        int bb = beat_cnt;
        int sb = str_q.size();
        bit ok;
        logic [31:0] d;
        logic [2:0]  exp_cti [5] = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b111};
        wb_write(5'h04, 32'h100);
        wb_write(5'h08, 32'd20);
        wb_write(5'h0C, 32'd4);
        wb_write(5'h00, 32'h1);
        wait_irq(200, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL partial_irq: got 0 expected 1"); end
        tests_run++;
        if (beat_cnt - bb !== 5 || str_q.size() - sb !== 5) begin
            tests_failed++;
            $display("FAIL partial_count: got beats %0d words %0d expected 5 5", beat_cnt - bb, str_q.size() - sb);
        end
        for (int i = 0; i < 5; i++) begin
            if (bb + i < beat_adr.size() && sb + i < str_q.size()) begin
                tests_run++;
                if (beat_adr[bb+i] !== 32'h100 + 32'(4 * i) || beat_cti[bb+i] !== exp_cti[i] ||
                    str_q[sb+i] !== 32'hC0DE_0040 + 32'(i)) begin
                    tests_failed++;
                    $display("FAIL partial_beat%0d: got adr %h cti %b data %h expected %h %b %h", i,
                             beat_adr[bb+i], beat_cti[bb+i], str_q[sb+i],
                             32'h100 + 32'(4 * i), exp_cti[i], 32'hC0DE_0040 + 32'(i));
                end
            end
        end
        wb_write(5'h00, 32'h2);
        wb_write(5'h00, 32'h8);
        wb_read(5'h00, d);
        tests_run++;
`ifdef WB_STREAM_WRITER_REPEAT_EN
        if (d !== 32'h8) begin tests_failed++; $display("FAIL repeat_bit: got %h expected 8", d); end
        wb_write(5'h00, 32'h0);
`else
        if (d !== 32'h0) begin tests_failed++; $display("FAIL repeat_bit: got %h expected 0", d); end
`endif
    endtask

    task automatic test_backpressure;
        int bb = beat_cnt;
        int sb = str_q.size();
        int bad = 0;
        bit ok;
        bus.stream_m_ready_i = 1'b0;
        wb_write(5'h04, 32'h400);
        wb_write(5'h08, 32'd256);
        wb_write(5'h0C, 32'd4);
        wb_write(5'h00, 32'h1);
        repeat (150) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (beat_cnt - bb !== 32 || bus.wbm_cyc_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_stall: got beats %0d cyc %b expected 32 0", beat_cnt - bb, bus.wbm_cyc_o);
        end
        tests_run++;
        if (bus.stream_m_valid_o !== 1'b1 || bus.stream_m_data_o !== 32'hC0DE_0100) begin
            tests_failed++;
            $display("FAIL bp_head: got valid %b data %h expected 1 c0de0100", bus.stream_m_valid_o, bus.stream_m_data_o);
        end
        @(posedge clk); #1 bus.stream_m_ready_i = 1'b1;
        wait_irq(600, ok);
        tests_run++;
        if (!ok || beat_cnt - bb !== 64 || str_q.size() - sb !== 64) begin
            tests_failed++;
            $display("FAIL bp_total: got irq %b beats %0d words %0d expected 1 64 64", ok, beat_cnt - bb, str_q.size() - sb);
        end
        for (int i = 0; i < 64; i++)
            if (sb + i >= str_q.size() || str_q[sb+i] !== 32'hC0DE_0100 + 32'(i)) bad++;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL bp_order: got %0d wrong words expected 0", bad); end
        wb_write(5'h00, 32'h2);
    endtask

    task automatic test_bus_error;
        int bb = beat_cnt;
        bit ok;
        logic [31:0] d;
        bus.stream_m_ready_i = 1'b0;
        err_at = beat_cnt + 2;
        err_en = 1'b1;
        wb_write(5'h04, 32'h800);
        wb_write(5'h08, 32'd32);
        wb_write(5'h0C, 32'd4);
        wb_write(5'h00, 32'h1);
        wait_irq(100, ok);
        @(negedge clk);
        err_en = 1'b0;
        tests_run++;
        if (!ok || beat_cnt - bb !== 2 || bus.wbm_cyc_o !== 1'b0 || bus.stream_m_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_state: got irq %b beats %0d cyc %b valid %b expected 1 2 0 0",
                     ok, beat_cnt - bb, bus.wbm_cyc_o, bus.stream_m_valid_o);
        end
        wb_read(5'h00, d);
        tests_run++;
        if (d !== 32'h6) begin tests_failed++; $display("FAIL err_csr: got %h expected 6", d); end
        wb_write(5'h00, 32'h2);
        tests_run++;
        if (bus.irq_o !== 1'b0) begin tests_failed++; $display("FAIL err_irqclr: got %b expected 0", bus.irq_o); end
        wb_read(5'h00, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL err_csrclr: got %h expected 0", d); end
    endtask

    task automatic test_edge_config;
        int bb = beat_cnt;
        bit ok;
        logic [31:0] d;
        wb_write(5'h08, 32'd0);
        wb_write(5'h04, 32'h40);
        wb_write(5'h00, 32'h1);
        wait_irq(20, ok);
        repeat (3) @(posedge clk);
        tests_run++;
        if (!ok || beat_cnt !== bb) begin
            tests_failed++;
            $display("FAIL zero_size: got irq %b beats %0d expected 1 0", ok, beat_cnt - bb);
        end
        wb_read(5'h00, d);
        tests_run++;
        if (d !== 32'h2) begin tests_failed++; $display("FAIL zero_csr: got %h expected 2", d); end
        // Leave irq set; stall the bus after two beats so the engine stays mid-burst.
        ack_limit = beat_cnt + 2;
        bus.stream_m_ready_i = 1'b0;
        wb_write(5'h08, 32'd32);
        wb_write(5'h0C, 32'd4);
        wb_write(5'h00, 32'h1);
        repeat (10) @(posedge clk);
        wb_write(5'h04, 32'h999C);
        wb_read(5'h04, d);
        tests_run++;
        if (d !== 32'h40) begin tests_failed++; $display("FAIL busy_addr: got %h expected 40", d); end
        wb_read(5'h00, d);
        tests_run++;
        if (d !== 32'h3) begin tests_failed++; $display("FAIL busy_csr: got %h expected 3", d); end
    endtask

    task automatic test_reset_mid_burst;
        logic [31:0] d;
        @(negedge clk);
        tests_run++;
        if ({bus.wbm_cyc_o, bus.stream_m_valid_o, bus.irq_o} !== 3'b111) begin
            tests_failed++;
            $display("FAIL midrst_pre: got %b expected 111", {bus.wbm_cyc_o, bus.stream_m_valid_o, bus.irq_o});
        end
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.stream_m_valid_o, bus.irq_o} !== 4'b0 || bus.wbm_adr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_out: got %b adr %h expected 0000 0",
                     {bus.wbm_cyc_o, bus.wbm_stb_o, bus.stream_m_valid_o, bus.irq_o}, bus.wbm_adr_o);
        end
        ack_limit = 1 << 30;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            wb_read(5'(4 * a), d);
            tests_run++;
            if (d !== 32'h0) begin tests_failed++; $display("FAIL midrst_reg%0d: got %h expected 0", a, d); end
        end
    endtask

    initial begin
        bus.wbs_adr_i = '0; bus.wbs_dat_i = '0; bus.wbs_sel_i = '1;
        bus.wbs_we_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        bus.wbs_cti_i = '0; bus.wbs_bte_i = '0;
        bus.stream_m_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_partial_burst();
        test_backpressure();
        test_bus_error();
        test_edge_config();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/wb_stream_writer.md
Name: wb_stream_writer

Overview:
DMA engine that moves data from memory to a stream, the opposite direction of wb_stream_reader.
- Reads a buffer from memory through a Wishbone B3 burst master into an internal FIFO.
- Presents the FIFO contents on a valid/ready stream master port.
- Configured through the same Wishbone slave register map as wb_stream_reader.
- Raises irq_o when the whole buffer has been delivered on the stream.

Parameters:
FIFO_AW, 5, FIFO depth is 2**FIFO_AW words
MAX_BURST_LEN, 32, maximum Wishbone burst length in words
WB_AW, 32, Wishbone address width
WB_DW, 32, Wishbone data width and stream data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
wbm_adr_o  out  WB_AW  memory read address (byte address)
wbm_dat_o  out  WB_DW  tied 0
wbm_sel_o  out  WB_DW/8  all ones
wbm_we_o  out  1  tied 0
wbm_cyc_o, wbm_stb_o  out  1  bus cycle / strobe
wbm_cti_o  out  3  010 incrementing, 111 last beat
wbm_bte_o  out  2  tied 00 (linear)
wbm_dat_i  in  WB_DW  read data
wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  slave response (rty ignored)
stream_m_data_o  out  WB_DW  stream data
stream_m_valid_o  out  1  data valid
stream_m_ready_i  in  1  sink ready
irq_o  out  1  level interrupt, equals CSR.irq
wbs_adr_i  in  5  config byte address
wbs_dat_i  in  WB_DW  config write data
wbs_sel_i  in  WB_DW/8  config byte select (ignored; full-word writes)
wbs_we_i, wbs_cyc_i, wbs_stb_i  in  1  config control
wbs_cti_i  in  3  config cycle type (ignored)
wbs_bte_i  in  2  config burst type (ignored)
wbs_dat_o  out  WB_DW  config read data
wbs_ack_o, wbs_err_o, wbs_rty_o  out  1  config response; err and rty tied 0

Behaviour:
Reset: all outputs are 0 except wbm_sel_o, which is all ones. All registers are 0, the FSM is in IDLE and the FIFO is empty.

Config slave:
- wbs_ack_o is a one-cycle pulse, asserted the cycle after cyc&stb&!ack.
- Register map:
  - 0x00 CSR: bit0 busy (read-only), bit1 irq, bit2 err.
    - Write bit0=1: start (ignored while busy).
    - Write bit1=1: clears irq and err.
  - 0x04 START_ADDR: byte address, word aligned.
  - 0x08 BUF_SIZE: bytes, multiple of WB_DW/8.
  - 0x0C BURST_SIZE: words.
- Writes to 0x04–0x0C while busy are ignored. Reads return the stored values; unmapped addresses read 0.

Effective burst length: eb = BURST_SIZE clamped to the range 1..min(MAX_BURST_LEN, 2**FIFO_AW).

Master FSM:
- IDLE:
  - On start with BUF_SIZE=0: set irq the next cycle; no bus cycles.
  - On start with BUF_SIZE>0: set busy, load ptr=START_ADDR and rem=BUF_SIZE/(WB_DW/8); go to WAIT.
- WAIT: when FIFO free space ≥ n = min(eb, rem), go to BURST.
- BURST:
  - Assert cyc/stb; adr = ptr, incremented by WB_DW/8 on each ack.
  - cti = 010 except on the beat with one word left in this burst, where cti = 111 (n=1 is a single 111 beat).
  - Each ack pushes wbm_dat_i into the FIFO and decrements rem.
  - After the last ack: drop cyc/stb the same cycle; go to WAIT if rem>0, else DRAIN.
  - err_i: drop cyc; set CSR.err and irq; flush the FIFO; go to IDLE.
- DRAIN: when the FIFO is empty and the final word has been accepted, set irq, clear busy, go to IDLE.

FIFO and stream:
- FIFO is first-word-fall-through: stream_m_valid_o = !empty and stream_m_data_o = head word.
- A word pops when valid&ready. Simultaneous push and pop on a full or empty FIFO is legal.
- FIFO never overflows because the WAIT space check precedes every burst.
- Addresses wrap modulo 2**WB_AW.
- Asserting rst_n low mid-burst drops cyc and returns everything to the reset state asynchronously.

Optional Feature:
WB_STREAM_WRITER_REPEAT_EN
- Defined: CSR bit3 repeat is read/write. With repeat=1, DRAIN sets irq and returns to WAIT with ptr=START_ADDR and rem reloaded (a circular buffer); busy stays set. Writing repeat=0 stops the engine at the end of the current buffer.
- Undefined: bit3 reads 0 and writes to it are ignored.

Test Plan:
- Basic burst: START_ADDR=0x40, BUF_SIZE=32, BURST_SIZE=4, sink always ready → two bursts, cti 010,010,010,111 each, adr 0x40..0x5C; the stream carries mem[0x10..0x17] in order; irq=1; CSR reads 0x2.
- Partial last burst: BUF_SIZE=20, BURST_SIZE=4 → bursts of 4 then 1 (single 111 beat); 5 stream words; irq.
- Backpressure: FIFO_AW=5, BUF_SIZE=256, ready=0 → cyc stops after 32 words are buffered; release ready → all 64 words delivered in order, no loss.
- Bus error: err_i on the 3rd beat → cyc drops; CSR=0x6; stream valid=0; write CSR=2 → irq=0.
- Edge config: BUF_SIZE=0 start → irq with no cyc; START_ADDR write while busy → readback unchanged.
- Reset: rst_n low mid-burst → cyc, stb, valid, irq and all registers read 0 immediately.
